expander_gate: RTL and testbench

Downward expander / noise gate, the complementary dynamics stage to the compressor: it attenuates the signal while its magnitude sits *below* a threshold and passes it at unity gain above it. It runs in the bclk domain of the audio core chain and processes one sample per lrclk frame. Gain follows an attack/hold/release envelope. The output multiply is a serial shift-add unit.

---
 rtl/expander_gate_if.sv | 35 +++
 rtl/expander_gate.sv | 207 ++++++++++++++++++++
 tb/tb_expander_gate.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/expander_gate_if.sv
// expander_gate_if
// Groups the frame-rate signals of the expander/noise gate.
//   master : drives lrclk, in, thr, ratio, attack, releas, hold
//            and observes out, valid, gate_open, dbg_state, dbg_gain
//   slave  : the expander_gate core (mirror image of master)
// Handshake: there is no backpressure. A rising lrclk edge, seen while the
// core is idle, offers one sample. valid is a single-cycle pulse marking the
// cycle in which out takes its new value. out holds its value between pulses.
interface expander_gate_if #(
  parameter int BITSIZE = 16,
  parameter int HOLD_W  = 16
);
  logic                      lrclk;
  logic signed [BITSIZE-1:0] in;
  logic        [BITSIZE-1:0] thr;
  logic        [BITSIZE-1:0] ratio;
  logic        [BITSIZE-1:0] attack;
  logic        [BITSIZE-1:0] releas;
  logic        [HOLD_W-1:0]  hold;
  logic signed [BITSIZE-1:0] out;
  logic                      valid;
  logic                      gate_open;
  logic        [2:0]         dbg_state;
  logic        [BITSIZE-1:0] dbg_gain;

  modport master (
    output lrclk, in, thr, ratio, attack, releas, hold,
    input  out, valid, gate_open, dbg_state, dbg_gain
  );

  modport slave (
    input  lrclk, in, thr, ratio, attack, releas, hold,
    output out, valid, gate_open, dbg_state, dbg_gain
  );
endinterface

// File: rtl/expander_gate.sv
// expander_gate
// Downward expander / noise gate. It attenuates the signal toward a floor
// gain while |in| is at or below thr, and passes it at unity gain above thr.
// The gain follows an attack / hold / release envelope and is stepped once per
// sample. The output multiply is a serial shift-add unit.
// Ports:
//   bclk   : clock; all logic runs on the rising edge
//   resetn : asynchronous active-low reset
//   io     : expander_gate_if.slave (sample, configuration, out/valid,
//            gate_open, and debug views of the FSM state and gain)
// Per-sample schedule, counted in bclk edges after the edge is seen:
//   edge 1     : capture the sample and |sample|, set busy
//   edge 2     : FSM/gain update, load the multiplier
//   edge 3..17 : 15 shift-add iterations; edge 17 also writes out and valid
module expander_gate #(
  parameter int BITSIZE = 16,
  parameter int HOLD_W  = 16
) (
  input  logic          bclk,
  input  logic          resetn,
  expander_gate_if.slave io
);
  localparam int SW = $clog2(BITSIZE);
  localparam int PW = 2 * BITSIZE;
  localparam logic [BITSIZE-1:0] UNITY = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] S_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_CLOSING = 3'd4;

  logic                      lrclk_q, lrclk_d;
  logic signed [BITSIZE-1:0] sample_q, sample_d;
  logic        [BITSIZE-1:0] mag_q, mag_d;
  logic                      busy_q, busy_d;
  logic        [SW-1:0]      step_q, step_d;
  logic        [2:0]         state_q, state_d;
  logic        [BITSIZE-1:0] gain_q, gain_d;
  logic        [HOLD_W-1:0]  cnt_q, cnt_d;
  logic signed [PW-1:0]      acc_q, acc_d;
  logic signed [PW-1:0]      mcand_q, mcand_d;
  logic        [BITSIZE-1:0] mplier_q, mplier_d;
  logic signed [BITSIZE-1:0] out_q, out_d;
  logic                      valid_q, valid_d;

  logic                      start, fsm_step, last_step, above;
  logic        [BITSIZE-1:0] mag_in, floor_v, att_base, att_gain, rel_gain;
  logic        [BITSIZE:0]   att_sum;
  logic                      att_full, rel_hit;
  logic signed [BITSIZE+1:0] rel_diff;
  logic signed [PW-1:0]      acc_sum;

  always_comb begin
    lrclk_d   = io.lrclk;
    // An edge arriving while a sample is in flight is dropped entirely.
    start     = io.lrclk & ~lrclk_q & ~busy_q;
    fsm_step  = busy_q & (step_q == '0);
    last_step = busy_q & (step_q == SW'(BITSIZE - 1));

    // |in|, with the most negative code saturating to the largest positive.
    if (io.in == $signed(S_MIN))    mag_in = UNITY;
    else if (io.in[BITSIZE-1])      mag_in = -io.in;
    else                            mag_in = io.in;

    above   = mag_q > io.thr;
    floor_v = (io.ratio > UNITY) ? UNITY : io.ratio;

    // Attack starts from the floor when leaving CLOSED, else from the live gain.
    att_base = (state_q == ST_CLOSED) ? floor_v : gain_q;
    att_sum  = {1'b0, att_base} + {1'b0, io.attack};
    att_full = att_sum >= {1'b0, UNITY};
    att_gain = att_full ? UNITY : att_sum[BITSIZE-1:0];

    // Release is evaluated two bits wider so the subtraction cannot wrap.
    rel_diff = $signed({2'b00, gain_q}) - $signed({2'b00, io.releas});
    rel_hit  = rel_diff <= $signed({2'b00, floor_v});
    rel_gain = rel_hit ? floor_v : rel_diff[BITSIZE-1:0];

    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    if (fsm_step) begin
      case (state_q)
        ST_CLOSED: begin
          if (above) begin
            gain_d  = att_gain;
            state_d = att_full ? ST_OPEN : ST_OPENING;
          end else begin
            gain_d  = floor_v;
          end
        end
        ST_OPENING: begin
          if (above) begin
            gain_d  = att_gain;
            state_d = att_full ? ST_OPEN : ST_OPENING;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = io.hold;
          end
        end
        ST_OPEN: begin
          if (!above) begin
            state_d = ST_HOLD;
            cnt_d   = io.hold;
          end
        end
        ST_HOLD: begin
          if (above) begin
            gain_d  = att_gain;
            state_d = att_full ? ST_OPEN : ST_OPENING;
          end else if (cnt_q == '0) begin
            gain_d  = rel_gain;
            state_d = rel_hit ? ST_CLOSED : ST_CLOSING;
          end else begin
            cnt_d   = cnt_q - 1'b1;
          end
        end
        ST_CLOSING: begin
          if (above) begin
            gain_d  = att_gain;
            state_d = att_full ? ST_OPEN : ST_OPENING;
          end else begin
            gain_d  = rel_gain;
            state_d = rel_hit ? ST_CLOSED : ST_CLOSING;
          end
        end
        default: state_d = ST_CLOSED;
      endcase
    end

    // Serial multiply: the multiplicand shifts left, the gain shifts right,
    // one partial product per cycle.
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    sample_d = sample_q;
    mag_d    = mag_q;
    busy_d   = busy_q;
    step_d   = step_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    if (start) begin
      sample_d = io.in;
      mag_d    = mag_in;
      busy_d   = 1'b1;
      step_d   = '0;
    end else if (fsm_step) begin
      acc_d    = '0;
      mcand_d  = {{BITSIZE{sample_q[BITSIZE-1]}}, sample_q};
      mplier_d = gain_d;
      step_d   = SW'(1);
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 1'b1;
      if (last_step) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        // Unity gain bypasses the multiply so the sample passes bit-exact.
        out_d   = (gain_q == UNITY) ? sample_q : acc_sum[PW-2:BITSIZE-1];
      end
    end
  end

  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      lrclk_q  <= 1'b1;
      sample_q <= '0;
      mag_q    <= '0;
      busy_q   <= 1'b0;
      step_q   <= '0;
      state_q  <= ST_CLOSED;
      gain_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      lrclk_q  <= lrclk_d;
      sample_q <= sample_d;
      mag_q    <= mag_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      state_q  <= state_d;
      gain_q   <= gain_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign io.out       = out_q;
  assign io.valid     = valid_q;
  assign io.gate_open = (state_q == ST_OPENING) || (state_q == ST_OPEN) ||
                        (state_q == ST_HOLD);
  assign io.dbg_state = state_q;
  assign io.dbg_gain  = gain_q;
endmodule

// File: tb/tb_expander_gate.sv
// tb_expander_gate
// Frame-level bench for expander_gate: each frame drives one sample with its
// configuration, a reference model of the gain envelope pushes the expected
// output to exp_q, and the output is popped and compared on valid.
module tb_expander_gate;
  localparam int C_CLOSED  = 0;
  localparam int C_OPENING = 1;
  localparam int C_OPEN    = 2;
  localparam int C_HOLD    = 3;
  localparam int C_CLOSING = 4;

  logic bclk;
  logic resetn;
  expander_gate_if #(.BITSIZE(16), .HOLD_W(16)) gif ();

  expander_gate #(.BITSIZE(16), .HOLD_W(16)) dut (
    .bclk   (bclk),
    .resetn (resetn),
    .io     (gif)
  );

  // Clock / reset
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int checks;
  int failures;
  logic [15:0] exp_q[$];

  // Reference model state
  int m_gain;
  int m_state;
  int m_cnt;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_attack(input int base, input int a);
    m_gain = base + a;
    if (m_gain >= 32767) begin
      m_gain  = 32767;
      m_state = C_OPEN;
    end else begin
      m_state = C_OPENING;
    end
  endtask

  task automatic model_release(input int rl, input int fl);
    m_gain = m_gain - rl;
    if (m_gain <= fl) begin
      m_gain  = fl;
      m_state = C_CLOSED;
    end else begin
      m_state = C_CLOSING;
    end
  endtask

  // One envelope step plus the expected output sample.
  task automatic model_step(input int s, input int t, input int r,
                            input int a, input int rl, input int h,
                            output int exp_out);
    int fl;
    int mag;
    bit above;
    longint p;
    fl    = (r > 32767) ? 32767 : r;
    mag   = (s == -32768) ? 32767 : ((s < 0) ? -s : s);
    above = mag > t;
    case (m_state)
      C_CLOSED:  if (above) model_attack(fl, a); else m_gain = fl;
      C_OPENING: if (above) model_attack(m_gain, a);
                 else begin m_state = C_HOLD; m_cnt = h; end
      C_OPEN:    if (!above) begin m_state = C_HOLD; m_cnt = h; end
      C_HOLD:    if (above) model_attack(m_gain, a);
                 else if (m_cnt == 0) model_release(rl, fl);
                 else m_cnt = m_cnt - 1;
      default:   if (above) model_attack(m_gain, a); else model_release(rl, fl);
    endcase
    if (m_gain == 32767) begin
      exp_out = s;
    end else begin
      p = longint'(s) * longint'(m_gain);
      exp_out = int'(p >>> 15);
    end
  endtask

  task automatic model_reset();
    m_gain  = 0;
    m_state = C_CLOSED;
    m_cnt   = 0;
  endtask

  // Driver: one full 32-bclk frame. second_edge adds an extra lrclk rise at
  // edge 8 that must be ignored.
  task automatic run_frame(input int s, input int t, input int r, input int a,
                           input int rl, input int h, input bit second_edge);
    int exp_out;
    int seen;
    bit exp_gate;
    @(negedge bclk);
    gif.in     = 16'(s);
    gif.thr    = 16'(t);
    gif.ratio  = 16'(r);
    gif.attack = 16'(a);
    gif.releas = 16'(rl);
    gif.hold   = 16'(h);
    gif.lrclk  = 1'b1;
    model_step(s, t, r, a, rl, h, exp_out);
    exp_q.push_back(16'(exp_out));
    exp_gate = (m_state == C_OPENING) || (m_state == C_OPEN) || (m_state == C_HOLD);
    seen = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge bclk);
      #1;
      if (k == 2) begin
        check_val("gain", int'(gif.dbg_gain), m_gain);
        check_val("state", int'(gif.dbg_state), m_state);
        check_val("gate_open", int'(gif.gate_open), int'(exp_gate));
      end
      if (gif.valid) begin
        seen++;
        check_val("latency", k, 17);
        if (exp_q.size() > 0) check_val("out", int'(gif.out), int'($signed(exp_q.pop_front())));
      end
      if (second_edge && k == 4) gif.lrclk = 1'b0;
      if (second_edge && k == 7) gif.lrclk = 1'b1;
      if (k == 16) gif.lrclk = 1'b0;
    end
    check_val("valid_count", seen, 1);
    exp_q.delete();
  endtask

  // Frame with reset asserted mid-multiply: nothing may come out.
  task automatic run_reset_frame(input int s, input int t, input int r);
    int seen;
    @(negedge bclk);
    gif.in    = 16'(s);
    gif.thr   = 16'(t);
    gif.ratio = 16'(r);
    gif.lrclk = 1'b1;
    seen = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge bclk);
      #1;
      if (gif.valid) seen++;
      if (k == 10) resetn = 1'b0;
      if (k == 12) resetn = 1'b1;
      if (k == 16) gif.lrclk = 1'b0;
    end
    model_reset();
    check_val("rst_mid_valid", seen, 0);
    check_val("rst_mid_out", int'(gif.out), 0);
    check_val("rst_mid_gate", int'(gif.gate_open), 0);
    check_val("rst_mid_gain", int'(gif.dbg_gain), 0);
    check_val("rst_mid_state", int'(gif.dbg_state), C_CLOSED);
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    model_reset();
    resetn     = 1'b0;
    gif.lrclk  = 1'b1;
    gif.in     = '0;
    gif.thr    = '0;
    gif.ratio  = '0;
    gif.attack = '0;
    gif.releas = '0;
    gif.hold   = '0;
    repeat (3) @(posedge bclk);
    #1;
    check_val("rst_out", int'(gif.out), 0);
    check_val("rst_valid", int'(gif.valid), 0);
    check_val("rst_gate", int'(gif.gate_open), 0);
    check_val("rst_gain", int'(gif.dbg_gain), 0);
    check_val("rst_state", int'(gif.dbg_state), C_CLOSED);
    // Release reset with lrclk already high: no frame may start.
    @(negedge bclk);
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge bclk);
      #1;
      if (gif.valid) seen++;
    end
    check_val("no_false_edge", seen, 0);
    check_val("no_false_gain", int'(gif.dbg_gain), 0);
    @(negedge bclk);
    gif.lrclk = 1'b0;
    repeat (4) @(posedge bclk);

    // Closed gate at floor 0x0800
    run_frame(100, 1000, 16'h0800, 0, 0, 0, 0);

    // Opening ramp with attack 0x2000 from a zero floor
    for (int f = 0; f < 4; f++) run_frame(20000, 1000, 0, 16'h2000, 0, 0, 0);

    // Hold for 3 frames then release by 0x4000 down to the 0x1000 floor
    for (int f = 0; f < 6; f++) run_frame(10, 1000, 16'h1000, 0, 16'h4000, 3, 0);

    // Magnitude boundaries on the most negative sample and thr == mag
    run_frame(-32768, 32767, 16'h1000, 16'h2000, 0, 0, 0);
    run_frame(500, 500, 16'h1000, 16'h2000, 0, 0, 0);
    run_frame(-32768, 32766, 16'h1000, 16'h2000, 0, 0, 0);

    // Open fully, drop to CLOSING at 0x5000, then re-open with attack 0x1000
    run_frame(20000, 1000, 0, 16'h7FFF, 0, 0, 0);
    run_frame(10, 1000, 0, 0, 16'h2FFF, 0, 0);
    run_frame(10, 1000, 0, 0, 16'h2FFF, 0, 0);
    run_frame(20000, 1000, 0, 16'h1000, 0, 0, 0);

    // Ratio above unity clamps the floor
    run_frame(-1234, 30000, 16'hFFFF, 0, 16'h0100, 0, 0);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      run_frame(int'($signed(16'($urandom_range(0, 65535)))),
                $urandom_range(0, 20000), $urandom_range(0, 65535),
                $urandom_range(0, 16'h4000), $urandom_range(0, 16'h4000),
                $urandom_range(0, 3), 0);
    end

    // Extra lrclk rise while busy is ignored
    run_frame(-7000, 1000, 16'h0400, 16'h3000, 16'h1000, 1, 1);

    // Reset in the middle of a multiply
    run_reset_frame(20000, 100, 16'h2000);

    // Normal operation resumes after the mid-frame reset
    run_frame(3000, 1000, 16'h0800, 16'h1000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
